join_param: RTL and testbench

- Clocked 4-phase request/acknowledge join. It merges SIZE upstream channels into one downstream channel.
- req_out rises only once every req_in is high; the single downstream ack_out is broadcast back to all upstream ack_in.
- It sits between parallel producer stages and one consumer stage in the handshake pipeline.
- Request/ack inputs may be asynchronous to clk, so they are synchronized internally.

---
 rtl/join_pkg.sv | 5 +
 rtl/sync_bit.sv | 23 ++
 rtl/join_param.sv | 49 ++++
 tb/tb_join_param.sv | 137 +++++++++++++
 4 files changed

// File: rtl/join_pkg.sv
// join_pkg: shared constants and phase enum for the request/acknowledge join.
package join_pkg;
  localparam int SYNC_STAGES_DEF = 2;
  typedef enum logic {IDLE, REQ_HIGH} phase_t;
endpackage

// File: rtl/sync_bit.sv
// sync_bit: STAGES-deep flop chain with async active-low reset; STAGES=0 passes straight through.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  if (STAGES == 0) begin : g_bypass
    assign q_o = d_i;
  end else begin : g_chain
    logic [STAGES-1:0] chain_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chain_q <= '0;
      else begin
        chain_q[0] <= d_i;
        for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
      end
    end
    assign q_o = chain_q[STAGES-1];
  end
endmodule

// File: rtl/join_param.sv
// join_param: C-element join of size upstream 4-phase channels into one downstream channel,
// with synchronized inputs and a sticky protocol violation flag.
module join_param
  import join_pkg::*;
#(
  parameter int size        = 2,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [size-1:0] req_in,
  output logic [size-1:0] ack_in,
  output logic            req_out,
  input  logic            ack_out,
  output logic            protocol_err
);
  logic [size-1:0] req_s, req_prev_q;
  logic            ack_s, ack_prev_q, ack_q, err_q, err_d;
  phase_t          phase_q, phase_d;
  for (genvar g = 0; g < size; g++) begin : g_req_sync
    sync_bit #(.STAGES(SYNC_STAGES)) u_req (.clk(clk), .rst_n(rst_n), .d_i(req_in[g]), .q_o(req_s[g]));
  end
  sync_bit #(.STAGES(SYNC_STAGES)) u_ack (.clk(clk), .rst_n(rst_n), .d_i(ack_out), .q_o(ack_s));
  // Set and clear are mutually exclusive since they need opposite ack_s values.
  always_comb begin
    phase_d = (&req_s && !ack_s) ? REQ_HIGH : (~|req_s && ack_s) ? IDLE : phase_q;
    err_d   = err_q
            | (phase_q == REQ_HIGH && !ack_s && |(req_prev_q & ~req_s))
            | (phase_q == IDLE && ack_s && !ack_prev_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= IDLE;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      req_prev_q <= '0;
      ack_prev_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      ack_q      <= ack_s;
      err_q      <= err_d;
      req_prev_q <= req_s;
      ack_prev_q <= ack_s;
    end
  end
  assign req_out      = (phase_q == REQ_HIGH);
  assign ack_in       = {size{ack_q}};
  assign protocol_err = err_q;
endmodule

// File: tb/tb_join_param.sv
// tb_join_param: directed and randomized checks of join_param against a delayed-input reference model.
module tb_join_param;
  logic       clk = 1'b0, rst_n = 1'b0, req_out, ack_out = 1'b0, protocol_err;
  logic [1:0] req_in = 2'b00, ack_in;
  int n_chk = 0, n_fail = 0;
  logic [1:0] h_req [2];
  logic       h_ack [2];
  logic       m_req_out, m_err, m_prev_ack;
  logic [1:0] m_ack_in, m_prev_req;

  join_param #(.size(2), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .ack_in(ack_in),
    .req_out(req_out), .ack_out(ack_out), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    h_req = '{2'b00, 2'b00};
    h_ack = '{1'b0, 1'b0};
    m_req_out = 0; m_err = 0; m_prev_ack = 0; m_ack_in = 0; m_prev_req = 0;
  endtask

  // Inputs reach the decision logic two edges after being sampled.
  task automatic model_edge();
    logic [1:0] rs;
    logic as;
    rs = h_req[1];
    as = h_ack[1];
    if (m_req_out && !as && (m_prev_req & ~rs) != 0) m_err = 1;
    if (as && !m_prev_ack && !m_req_out) m_err = 1;
    if (rs == 2'b11 && !as) m_req_out = 1;
    else if (rs == 2'b00 && as) m_req_out = 0;
    m_ack_in = {2{as}};
    m_prev_req = rs;
    m_prev_ack = as;
    h_req[1] = h_req[0]; h_ack[1] = h_ack[0];
    h_req[0] = req_in;   h_ack[0] = ack_out;
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (rst_n) model_edge();
      @(negedge clk);
      chk("req_out", req_out, m_req_out);
      chk("ack_in", ack_in, m_ack_in);
      chk("protocol_err", protocol_err, m_err);
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    tick(2);
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    #1;
    chk("por_req_out", req_out, 0);
    chk("por_ack_in", ack_in, 0);
    chk("por_err", protocol_err, 0);
    do_reset();
    // Partial join never fires
    req_in = 2'b01; tick(10);
    chk("partial01", req_out, 0);
    req_in = 2'b10; tick(10);
    chk("partial10", req_out, 0);
    req_in = 2'b11; tick(2);
    chk("join_lat2", req_out, 0);
    tick(1);
    chk("join_lat3", req_out, 1);
    // Rest of full 4-phase cycle
    ack_out = 1; tick(2);
    chk("ack_lat2", ack_in, 2'b00);
    tick(1);
    chk("ack_lat3", ack_in, 2'b11);
    req_in = 2'b00; tick(3);
    chk("release", req_out, 0);
    ack_out = 0; tick(3);
    chk("ack_low", ack_in, 2'b00);
    chk("cycle_err", protocol_err, 0);
    // Ack held high gates the join
    ack_out = 1; tick(4);
    req_in = 2'b11; tick(10);
    chk("gated", req_out, 0);
    ack_out = 0; tick(2);
    chk("ungate_lat2", req_out, 0);
    tick(1);
    chk("ungate_lat3", req_out, 1);
    // Release without ack holds req_out and flags error
    do_reset();
    req_in = 2'b11; tick(4);
    chk("hold_pre", req_out, 1);
    req_in = 2'b00; tick(10);
    chk("hold_req", req_out, 1);
    chk("hold_err", protocol_err, 1);
    // Asynchronous reset mid-handshake
    do_reset();
    req_in = 2'b11; tick(4);
    ack_out = 1; tick(4);
    chk("mid_req", req_out, 1);
    chk("mid_ack", ack_in, 2'b11);
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("async_req", req_out, 0);
    chk("async_ack", ack_in, 2'b00);
    chk("async_err", protocol_err, 0);
    req_in = 2'b00; ack_out = 0;
    @(negedge clk);
    rst_n = 1;
    tick(10);
    chk("idle_req", req_out, 0);
    chk("idle_ack", ack_in, 2'b00);
    chk("idle_err", protocol_err, 0);
    // Randomized traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      if ($urandom_range(0, 3) == 0) req_in = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) ack_out = 1'($urandom_range(0, 1));
      tick(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
